// File: rtl/universal_shift_register_if.sv
// Control/data bundle for universal_shift_register. The master drives the controls
// and parallel data, and the slave returns register contents and burst status.
interface universal_shift_register_if #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
);
    logic             load;
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             serial_in;
    logic [N-1:0]     data_in;
    logic [N-1:0]     data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output load, en, start, mode, amount, serial_in, data_in,
        input  data_out, serial_out, busy, done
    );

    modport slave (
        input  load, en, start, mode, amount, serial_in, data_in,
        output data_out, serial_out, busy, done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register with single-step shifts and multi-cycle burst shifts.
// A burst latches its mode and performs one step per cycle, then pulses done.
module universal_shift_register #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    universal_shift_register_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        M_SRL  = 3'd0,
        M_SLL  = 3'd1,
        M_SRA  = 3'd2,
        M_ROR  = 3'd3,
        M_ROL  = 3'd4,
        M_SIR  = 3'd5,
        M_SIL  = 3'd6,
        M_HOLD = 3'd7
    } shift_mode_e;

    state_e           state_q, state_d;
    logic [N-1:0]     data_q, data_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    shift_mode_e      mode_lat_q, mode_lat_d;

    shift_mode_e      step_mode;
    logic             fill_r;
    logic             fill_l;
    logic [N-1:0]     shr;
    logic [N-1:0]     shl;
    logic [N-1:0]     step_data;
    logic             step_sout;

    // During a burst the latched mode drives the step. Otherwise the live mode
    // is used, which also covers the first step taken on the accepting edge.
    always_comb begin
        if (state_q == ST_SHIFT) begin
            step_mode = mode_lat_q;
        end else begin
            step_mode = shift_mode_e'(bus.mode);
        end
    end

    always_comb begin
        fill_r = 1'b0;
        fill_l = 1'b0;
        case (step_mode)
            M_SRA:   fill_r = data_q[N-1];
            M_ROR:   fill_r = data_q[0];
            M_SIR:   fill_r = bus.serial_in;
            default: fill_r = 1'b0;
        endcase
        case (step_mode)
            M_ROL:   fill_l = data_q[N-1];
            M_SIL:   fill_l = bus.serial_in;
            default: fill_l = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            if (gi == N - 1) begin : g_msb
                assign shr[gi] = fill_r;
            end else begin : g_mid_r
                assign shr[gi] = data_q[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign shl[gi] = fill_l;
            end else begin : g_mid_l
                assign shl[gi] = data_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        step_data = data_q;
        step_sout = sout_q;
        case (step_mode)
            M_SRL, M_SRA, M_ROR, M_SIR: begin
                step_data = shr;
                step_sout = data_q[0];
            end
            M_SLL, M_ROL, M_SIL: begin
                step_data = shl;
                step_sout = data_q[N-1];
            end
            default: begin
                step_data = data_q;
                step_sout = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sout_d      = sout_q;
        remaining_d = remaining_q;
        mode_lat_d  = mode_lat_q;
        case (state_q)
            ST_SHIFT: begin
                if (bus.load) begin
                    // A load aborts the burst, and no done pulse follows.
                    data_d      = bus.data_in;
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    data_d      = step_data;
                    sout_d      = step_sout;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (bus.load) begin
                    data_d = bus.data_in;
                end else if (bus.start) begin
                    if (bus.amount == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        mode_lat_d = shift_mode_e'(bus.mode);
                        data_d     = step_data;
                        sout_d     = step_sout;
                        if (bus.amount == CNT_W'(1)) begin
                            remaining_d = '0;
                            state_d     = ST_DONE;
                        end else begin
                            remaining_d = bus.amount - CNT_W'(1);
                            state_d     = ST_SHIFT;
                        end
                    end
                end else if (bus.en) begin
                    data_d = step_data;
                    sout_d = step_sout;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            sout_q      <= 1'b0;
            remaining_q <= '0;
            mode_lat_q  <= M_SRL;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sout_q      <= sout_d;
            remaining_q <= remaining_d;
            mode_lat_q  <= mode_lat_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.serial_out = sout_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register with N=8.
// Expected values are hand-computed, and inputs change 1 ns after each rising edge.
module tb_universal_shift_register;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    universal_shift_register_if #(.N(N), .CNT_W(CNT_W)) bus_if ();

    universal_shift_register #(.N(N), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("check %s ok: 0x%0h", tag, obs);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic so,
                             input logic b, input logic dn);
        check_eq({tag, "_data"}, 32'(bus_if.data_out), 32'(d));
        check_eq({tag, "_sout"}, 32'(bus_if.serial_out), 32'(so));
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'(b));
        check_eq({tag, "_done"}, 32'(bus_if.done), 32'(dn));
    endtask

    task automatic do_load(input logic [7:0] v);
        bus_if.load    = 1'b1;
        bus_if.data_in = v;
        tick();
        bus_if.load    = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.load      = 1'b0;
        bus_if.en        = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.mode      = 3'd0;
        bus_if.amount    = '0;
        bus_if.serial_in = 1'b0;
        bus_if.data_in   = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: disturb the state, then reset for two cycles
        do_load(8'h5A);
        bus_if.en = 1'b1; bus_if.mode = 3'd1;
        tick();
        bus_if.en = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // 2: single SRL step
        do_load(8'hA5);
        bus_if.en = 1'b1; bus_if.mode = 3'd0;
        tick();
        bus_if.en = 1'b0;
        check_out("srl_step", 8'h52, 1'b1, 1'b0, 1'b0);

        // 3: SRA burst of 3
        do_load(8'h81);
        bus_if.start = 1'b1; bus_if.mode = 3'd2; bus_if.amount = 4'd3;
        tick();
        bus_if.start = 1'b0;
        check_out("sra_e0", 8'hC0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("sra_e1", 8'hE0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("sra_e2", 8'hF0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("sra_done_clear", 32'(bus_if.done), 32'd0);

        // 4: ROL burst of 8 returns to the start value
        do_load(8'h96);
        bus_if.start = 1'b1; bus_if.mode = 3'd4; bus_if.amount = 4'd8;
        tick();
        bus_if.start = 1'b0;
        check_out("rol_e0", 8'h2D, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("rol_e6_busy", 32'(bus_if.busy), 32'd1);
        tick();
        check_out("rol_e7", 8'h96, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("rol_done_clear", 32'(bus_if.done), 32'd0);
        bus_if.start = 1'b1; bus_if.amount = 4'd0;
        tick();
        bus_if.start = 1'b0;
        check_out("amt0", 8'h96, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("amt0_done_clear", 32'(bus_if.done), 32'd0);

        // 5a: load aborts a ROR burst
        do_load(8'h0F);
        bus_if.start = 1'b1; bus_if.mode = 3'd3; bus_if.amount = 4'd5;
        tick();
        bus_if.start = 1'b0;
        check_eq("ror_e0_data", 32'(bus_if.data_out), 32'h87);
        tick();
        check_eq("ror_e1_data", 32'(bus_if.data_out), 32'hC3);
        do_load(8'h3C);
        check_out("abort_load", 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("abort_load_nodone", 32'(bus_if.done), 32'd0);

        // 5b: reset aborts a ROR burst
        do_load(8'h0F);
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("abort_rst_nodone", 32'(bus_if.done), 32'd0);

        // 6: SIL single steps, then an SIR burst with mode/en/start toggled mid-burst
        do_load(8'h00);
        bus_if.en = 1'b1; bus_if.mode = 3'd6; bus_if.serial_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus_if.en = 1'b0;
        check_out("sil4", 8'h0F, 1'b0, 1'b0, 1'b0);
        bus_if.start = 1'b1; bus_if.mode = 3'd5; bus_if.amount = 4'd4;
        tick();
        bus_if.start = 1'b0;
        check_eq("sir_e0_data", 32'(bus_if.data_out), 32'h87);
        bus_if.mode = 3'd1; bus_if.en = 1'b1; bus_if.start = 1'b1; bus_if.amount = 4'd1;
        tick();
        tick();
        tick();
        bus_if.en = 1'b0; bus_if.start = 1'b0;
        check_out("sir_e3", 8'hF0, 1'b1, 1'b0, 1'b1);
        tick();
        bus_if.serial_in = 1'b0;

        // amount > N: SRL by 10 clears the register
        do_load(8'hFF);
        bus_if.start = 1'b1; bus_if.mode = 3'd0; bus_if.amount = 4'd10;
        n = 0;
        do begin
            tick();
            bus_if.start = 1'b0;
            n++;
        end while (!bus_if.done && n < 20);
        check_eq("srl10_cycles", 32'(n), 32'd10);
        check_out("srl10", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // HOLD burst leaves data and serial_out alone but still pulses done
        do_load(8'h5A);
        bus_if.start = 1'b1; bus_if.mode = 3'd7; bus_if.amount = 4'd3;
        tick();
        bus_if.start = 1'b0;
        check_out("hold_e0", 8'h5A, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check_out("hold_e2", 8'h5A, 1'b0, 1'b0, 1'b1);
        tick();

        // load and start together: load wins
        bus_if.start = 1'b1; bus_if.mode = 3'd0; bus_if.amount = 4'd2;
        do_load(8'h33);
        bus_if.start = 1'b0;
        check_out("ld_start", 8'h33, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("ld_start_nodone", 32'(bus_if.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the team's basic load/enable shift register.
- Adds:
  - multiple shift modes (logical, arithmetic, rotate, serial-fill);
  - a serial output;
  - a multi-cycle "burst" shift of a programmable amount, with a busy/done handshake.
- Used by datapath blocks that need variable shifts without a barrel shifter, e.g. software-style multiply/divide sequencers.

Parameters:
- N, 8, register width in bits (N >= 2).
- CNT_W, $clog2(N+1), width of the burst shift-amount field.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  parallel load of data_in.
- en  input  1  single-step shift enable (idle only).
- start  input  1  begin burst shift of `amount` steps.
- mode  input  3  shift mode (encoding below).
- amount  input  CNT_W  burst length in steps.
- serial_in  input  1  fill bit for serial modes.
- data_in  input  N  parallel load data.
- data_out  output  N  register contents.
- serial_out  output  1  last bit shifted out.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse, burst completed.

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on rising clock edge.
- Reset values: data_out=0, serial_out=0, busy=0, done=0, FSM=IDLE, remaining count=0.
- Mode encoding, one step:
  - 0 SRL: right shift, fill 0.
  - 1 SLL: left shift, fill 0.
  - 2 SRA: right shift, fill data_out[N-1].
  - 3 ROR: rotate right.
  - 4 ROL: rotate left.
  - 5 SIR: right shift, fill MSB with serial_in.
  - 6 SIL: left shift, fill LSB with serial_in.
  - 7 HOLD: no change.
- serial_out per step:
  - right-type modes (0, 2, 3, 5) update it with old data_out[0];
  - left-type modes (1, 4, 6) update it with old data_out[N-1];
  - HOLD leaves it unchanged.
- Priority each edge: reset > load > start (IDLE/DONE only) > en (IDLE/DONE only).
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE:
  - load: data_out<=data_in; serial_out unchanged; next IDLE.
  - start with amount=0: no shift; next DONE.
  - start with amount=A>=1: mode latched; first step performed on the accepting edge.
    - A=1 -> next DONE.
    - A>1 -> next SHIFT, remaining=A-1.
  - en (no load/start): one step using the live mode; next IDLE.
  - otherwise: next IDLE.
- SHIFT:
  - One step per cycle using the latched mode; remaining decrements.
  - When remaining==1 the step is performed and next is DONE.
  - mode changes are ignored; en and start are ignored.
  - load aborts the burst: data_out<=data_in, next IDLE, no done pulse.
- Outputs decode from state:
  - busy=1 iff state==SHIFT;
  - done=1 iff state==DONE (exactly one cycle).
- Latency: a burst of A>=1 accepted at edge e0 finishes its last step at edge e0+A-1.
  - busy is high after edges e0..e0+A-2.
  - done is high for the cycle after edge e0+A-1.
- Boundary conditions:
  - amount > N executes literally: logical modes give 0; SRA gives all sign bits; rotates wrap modulo N.
  - HOLD burst: counts and pulses done, data unchanged.
  - Reset mid-burst: immediate return to reset values; no done pulse.
  - start and load in the same cycle: load wins; start is dropped.

Test Plan:
1. Assert reset 2 cycles from arbitrary state -> data_out=0x00, serial_out=0, busy=0, done=0.
2. Load 0xA5, then en=1, mode=0 for 1 cycle -> data_out=0x52, serial_out=1, busy stays 0.
3. Load 0x81; start, mode=2, amount=3 ->
   - data_out steps 0xC0, 0xE0, 0xF0 on consecutive edges;
   - busy high 2 cycles, then done high 1 cycle;
   - final serial_out=0.
4. Load 0x96; start, mode=4, amount=8 -> data_out returns to 0x96 after 8 edges, done pulses once. Then start amount=0 -> data unchanged, done pulses the next cycle.
5. Load 0x0F; start, mode=3, amount=5; assert load with data_in=0x3C on the 2nd busy cycle -> data_out=0x3C, busy=0 next cycle, no done pulse. Repeat with reset instead of load -> all outputs 0.
6. Load 0x00; en=1, mode=6, serial_in=1 for 4 cycles -> data_out=0x0F, serial_out=0. Toggling mode mid-burst (mode=5, amount=4) -> latched mode used throughout.
